// File: rtl/keypad_code_checker_if.sv
// Keypad code checker bus: keypad/config inputs and door status outputs.
// master = the side driving keypad strobes and code loads; slave = the checker.
interface keypad_code_checker_if #(
    parameter int CODE_LEN = 4,
    parameter int DIGIT_W  = 4
);
    localparam int CNT_W = $clog2(CODE_LEN + 1);

    logic                        digit_valid;
    logic [DIGIT_W-1:0]          digit_in;
    logic                        clear;
    logic                        code_load;
    logic [CODE_LEN*DIGIT_W-1:0] code_in;
    logic                        door_status_correct;
    logic                        door_status_incorrect;
    logic                        locked_out;
    logic [CNT_W-1:0]            digit_count;

    modport master (
        output digit_valid, digit_in, clear, code_load, code_in,
        input  door_status_correct, door_status_incorrect, locked_out, digit_count
    );

    modport slave (
        input  digit_valid, digit_in, clear, code_load, code_in,
        output door_status_correct, door_status_incorrect, locked_out, digit_count
    );
endinterface

// File: rtl/keypad_code_checker.sv
// Keypad code checker: collects CODE_LEN digits, compares them with a loadable
// stored code and pulses correct/incorrect one cycle after the last digit.
// Optional lockout after MAX_FAILS consecutive wrong entries is built only
// when KEYPAD_LOCKOUT_EN is defined; otherwise locked_out is tied low.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no digits collected, waiting for the first digit
// ENTRY   | partial entry in progress, inter-digit timeout running
// LOCKOUT | too many wrong entries, keypad ignored until timer expires
module keypad_code_checker #(
    parameter int                            CODE_LEN       = 4,
    parameter int                            DIGIT_W        = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0]   DEFAULT_CODE   = 16'h1234,
    parameter int                            TIMEOUT_CYCLES = 1000,
    parameter int                            MAX_FAILS      = 3,
    parameter int                            LOCKOUT_CYCLES = 5000
) (
    input  logic                  clk,
    input  logic                  reset,
    keypad_code_checker_if.slave  bus
);
    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int CNT_W  = $clog2(CODE_LEN + 1);
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(CODE_LEN - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD   = TMR_W'(TIMEOUT_CYCLES - 1);

`ifdef KEYPAD_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int LCK_W  = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LCK_W-1:0] LCK_LOAD = LCK_W'(LOCKOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_LOCKOUT} state_t;
`else
    typedef enum logic {S_IDLE, S_ENTRY} state_t;
`endif

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic [CODE_W-1:0]  entry, entry_nxt;
    logic [CODE_W-1:0]  code, code_nxt;
    logic [CODE_W-1:0]  entry_shift;
    logic [TMR_W-1:0]   timer, timer_nxt;
    logic               correct_q, correct_nxt;
    logic               incorrect_q, incorrect_nxt;
`ifdef KEYPAD_LOCKOUT_EN
    logic [FAIL_W-1:0]  fails, fails_nxt;
    logic [LCK_W-1:0]   lock_timer, lock_timer_nxt;
`endif

    // State and datapath registers, all cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            count       <= '0;
            entry       <= '0;
            code        <= DEFAULT_CODE;
            timer       <= '0;
            correct_q   <= 1'b0;
            incorrect_q <= 1'b0;
`ifdef KEYPAD_LOCKOUT_EN
            fails       <= '0;
            lock_timer  <= '0;
`endif
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            entry       <= entry_nxt;
            code        <= code_nxt;
            timer       <= timer_nxt;
            correct_q   <= correct_nxt;
            incorrect_q <= incorrect_nxt;
`ifdef KEYPAD_LOCKOUT_EN
            fails       <= fails_nxt;
            lock_timer  <= lock_timer_nxt;
`endif
        end
    end

    // Next-state: digit collection, compare on the last digit, timeout,
    // abort on clear/code_load, and lockout countdown.
    always_comb begin
        state_nxt     = state;
        count_nxt     = count;
        entry_nxt     = entry;
        code_nxt      = code;
        timer_nxt     = timer;
        correct_nxt   = 1'b0;
        incorrect_nxt = 1'b0;
`ifdef KEYPAD_LOCKOUT_EN
        fails_nxt      = fails;
        lock_timer_nxt = lock_timer;
`endif
        // Entry as it would look with the incoming digit appended; the
        // oldest digit falls off the top.
        entry_shift = CODE_W'({entry, bus.digit_in});

        // code_load is honoured in every state, including lockout.
        if (bus.code_load) begin
            code_nxt = bus.code_in;
        end

        case (state)
            S_IDLE, S_ENTRY: begin
                if (bus.code_load || bus.clear) begin
                    state_nxt = S_IDLE;
                    count_nxt = '0;
                    entry_nxt = '0;
                    timer_nxt = '0;
                end else if (bus.digit_valid) begin
                    if (count == LAST_DIGIT) begin
                        correct_nxt   = (entry_shift == code);
                        incorrect_nxt = (entry_shift != code);
                        state_nxt     = S_IDLE;
                        count_nxt     = '0;
                        entry_nxt     = '0;
                        timer_nxt     = '0;
`ifdef KEYPAD_LOCKOUT_EN
                        if (entry_shift == code) begin
                            fails_nxt = '0;
                        end else if (int'(fails) + 1 >= MAX_FAILS) begin
                            fails_nxt      = FAIL_W'(MAX_FAILS);
                            state_nxt      = S_LOCKOUT;
                            lock_timer_nxt = LCK_LOAD;
                        end else begin
                            fails_nxt = fails + 1'b1;
                        end
`endif
                    end else begin
                        state_nxt = S_ENTRY;
                        count_nxt = count + 1'b1;
                        entry_nxt = entry_shift;
                        timer_nxt = TMR_LOAD;
                    end
                end else if (state == S_ENTRY) begin
                    // Terminal count reached after TIMEOUT_CYCLES idle cycles.
                    if (timer == '0) begin
                        state_nxt = S_IDLE;
                        count_nxt = '0;
                        entry_nxt = '0;
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
            end
`ifdef KEYPAD_LOCKOUT_EN
            S_LOCKOUT: begin
                if (lock_timer == '0) begin
                    state_nxt = S_IDLE;
                    fails_nxt = '0;
                end else begin
                    lock_timer_nxt = lock_timer - 1'b1;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.door_status_correct   = correct_q;
    assign bus.door_status_incorrect = incorrect_q;
    assign bus.digit_count           = count;
`ifdef KEYPAD_LOCKOUT_EN
    assign bus.locked_out            = (state == S_LOCKOUT);
`else
    assign bus.locked_out            = 1'b0;
`endif
endmodule
